id_hazard_unit: RTL



---
 rtl/id_hazard_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/id_hazard_unit.sv
// ID-stage hazard unit: per-port operand forwarding, stall cause selection,
// outstanding-load scoreboard and a RUN/HOLD stall-length tracker.
module id_hazard_unit #(
  parameter int NREAD    = 2,
  parameter int DW       = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREAD*5-1:0]  raddr_i,
  input  logic [NREAD-1:0]    ren_i,
  input  logic [NREAD*DW-1:0] rf_rdata_i,
  input  logic                id_we_i,
  input  logic [4:0]          id_waddr_i,
  input  logic                id_is_load_i,
  input  logic                branch_flag_i,
  input  logic                jr_flag_i,
  input  logic                ex_we_i,
  input  logic [4:0]          ex_waddr_i,
  input  logic [DW-1:0]       ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_we_i,
  input  logic [4:0]          mem_waddr_i,
  input  logic [DW-1:0]       mem_wdata_i,
  input  logic                mem_is_load_i,
  input  logic                mem_ld_rdy_i,
  input  logic                wb_we_i,
  input  logic [4:0]          wb_waddr_i,
  input  logic [DW-1:0]       wb_wdata_i,
  input  logic                ld_issue_i,
  input  logic [4:0]          ld_issue_waddr_i,
  input  logic                ld_ret_i,
  input  logic [4:0]          ld_ret_waddr_i,
  input  logic [DW-1:0]       ld_ret_data_i,
  output logic [NREAD*DW-1:0] rdata_o,
  output logic                stall_o,
  output logic [2:0]          stall_cause_o,
  output logic [3:0]          pend_cnt_o,
  output logic [7:0]          stall_len_o
);

  localparam logic [3:0] MAXP = 4'(MAX_PEND);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  logic [31:0]      r_pend;
  logic [3:0]       r_cnt;
  logic             sb_err;
  state_t           r_state;
  logic [7:0]       r_len;

  logic [NREAD-1:0] w_c1, w_c2, w_c3, w_c4;
  logic             w_c5, w_c6;
  logic [2:0]       w_cause;

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_port
      logic [4:0]    w_a;
      logic          w_nz, w_ex_m, w_mem_m, w_wb_m, w_ret_m;
      logic [DW-1:0] w_fwd;

      assign w_a     = raddr_i[5*gi +: 5];
      assign w_nz    = (w_a != 5'd0);
      assign w_ex_m  = w_nz && ex_we_i  && (ex_waddr_i  == w_a);
      assign w_mem_m = w_nz && mem_we_i && (mem_waddr_i == w_a);
      assign w_wb_m  = w_nz && wb_we_i  && (wb_waddr_i  == w_a);
      assign w_ret_m = w_nz && ld_ret_i && (ld_ret_waddr_i == w_a);

      // Youngest usable producer wins; an EX load has no data yet.
      always_comb begin
        w_fwd = rf_rdata_i[DW*gi +: DW];
        if (w_ex_m && !ex_is_load_i)
          w_fwd = ex_wdata_i;
        else if (w_mem_m && (!mem_is_load_i || mem_ld_rdy_i))
          w_fwd = mem_wdata_i;
        else if (w_wb_m)
          w_fwd = wb_wdata_i;
        else if (w_ret_m)
          w_fwd = ld_ret_data_i;
      end

      assign rdata_o[DW*gi +: DW] = rst_i ? '0 : w_fwd;

      assign w_c1[gi] = ren_i[gi] && w_ex_m && ex_is_load_i;
      assign w_c2[gi] = ren_i[gi] && w_mem_m && mem_is_load_i && !mem_ld_rdy_i;
      assign w_c3[gi] = ren_i[gi] && (branch_flag_i || jr_flag_i) && w_ex_m;
      assign w_c4[gi] = ren_i[gi] && w_nz && r_pend[w_a] && !w_ret_m
                        && !(w_ex_m || w_mem_m || w_wb_m);
    end
  endgenerate

  assign w_c5 = id_we_i && (id_waddr_i != 5'd0) && r_pend[id_waddr_i]
                && !(ld_ret_i && (ld_ret_waddr_i == id_waddr_i));
  assign w_c6 = id_is_load_i && (r_cnt == MAXP) && !ld_ret_i;

  always_comb begin
    w_cause = 3'd0;
    if (rst_i)        w_cause = 3'd0;
    else if (|w_c1)   w_cause = 3'd1;
    else if (|w_c2)   w_cause = 3'd2;
    else if (|w_c3)   w_cause = 3'd3;
    else if (|w_c4)   w_cause = 3'd4;
    else if (w_c5)    w_cause = 3'd5;
    else if (w_c6)    w_cause = 3'd6;
  end

  assign stall_cause_o = w_cause;
  assign stall_o       = (w_cause != 3'd0);

  // Scoreboard: a return only counts if the register is actually pending.
  logic        w_ret_eff, w_issue_try, w_issue_busy, w_full, w_issue_ok, w_issue_bad;
  logic [31:0] w_pend_next;
  logic [3:0]  w_cnt_next;

  assign w_ret_eff    = ld_ret_i && (ld_ret_waddr_i != 5'd0) && r_pend[ld_ret_waddr_i];
  assign w_issue_try  = ld_issue_i && (ld_issue_waddr_i != 5'd0);
  assign w_issue_busy = r_pend[ld_issue_waddr_i]
                        && !(w_ret_eff && (ld_ret_waddr_i == ld_issue_waddr_i));
  assign w_full       = (r_cnt == MAXP) && !w_ret_eff;
  assign w_issue_ok   = w_issue_try && !w_issue_busy && !w_full;
  assign w_issue_bad  = w_issue_try && (w_issue_busy || w_full);

  always_comb begin
    w_pend_next = r_pend;
    if (w_ret_eff)  w_pend_next[ld_ret_waddr_i]   = 1'b0;
    if (w_issue_ok) w_pend_next[ld_issue_waddr_i] = 1'b1;
    w_cnt_next = r_cnt;
    if (w_issue_ok && !w_ret_eff)      w_cnt_next = r_cnt + 4'd1;
    else if (!w_issue_ok && w_ret_eff) w_cnt_next = r_cnt - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_cnt  <= '0;
      sb_err <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_cnt  <= w_cnt_next;
      if (w_issue_bad) sb_err <= 1'b1;
    end
  end

  // Stall tracker: length counts cycles spent in (or entering) HOLD.
  state_t     w_state_next;
  logic [7:0] w_len_next;

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    case (r_state)
      ST_RUN: begin
        if (stall_o) begin
          w_state_next = ST_HOLD;
          w_len_next   = 8'd1;
        end else begin
          w_len_next   = 8'd0;
        end
      end
      ST_HOLD: begin
        if (stall_o) begin
          w_len_next = (r_len == 8'hFF) ? r_len : r_len + 8'd1;
        end else begin
          w_state_next = ST_RUN;
          w_len_next   = 8'd0;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_len_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_len   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_len   <= w_len_next;
    end
  end

  assign pend_cnt_o  = r_cnt;
  assign stall_len_o = r_len;

endmodule
